// File: rtl/su_pkg.sv
// Shared types and constants for the MX11SU sequencer.
// Holds the sequencer state encoding and opcode-class constants.
package su_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        INCR   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6
    } su_seq_state_t;

    localparam logic [7:0] SU_HALT_OPC     = 8'hFF;
    localparam int         SU_MEM_TIMEOUT  = 16;

    localparam logic [3:0] SU_CLS_NOP5 = 4'h5;
    localparam logic [3:0] SU_CLS_JMP  = 4'hA;
    localparam logic [3:0] SU_CLS_LSU  = 4'hB;
    localparam logic [3:0] SU_CLS_NOPE = 4'hE;
    localparam logic [3:0] SU_CLS_SYS  = 4'hF;

    function automatic logic [3:0] su_opc_class(input logic [7:0] opc);
        return opc[7:4];
    endfunction

endpackage

// File: rtl/su_bus_timer.sv
// Memory wait-state watchdog: counts stalled request cycles and
// flags expiry on the last allowed cycle so the FSM can trap next edge.
module su_bus_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] CNT_MAX = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          stall;

    assign stall    = req_i & ~ack_i;
    assign expire_o = stall & (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/su_seq_ctrl.sv
// MX11SU instruction sequencer: fetch, INSP increment, decode, execute.
// Owns the instruction register and the memory-port handshake.
import su_pkg::*;

module su_seq_ctrl #(
    parameter int         MEM_TIMEOUT = SU_MEM_TIMEOUT,
    parameter logic [7:0] HALT_OPC    = SU_HALT_OPC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       mem_req,
    output logic       mem_ifetch,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       rom_load,
    input  logic       rom_store,
    output logic [7:0] insr,
    output logic       fetch,
    output logic       insr_le,
    output logic       ce_n,
    output logic       wb_stb,
    output logic       busy,
    output logic       halted,
    output logic       bus_err
);

    su_seq_state_t state_q, state_d;
    logic [7:0]    insr_q, insr_d;
    logic          mem_op;
    logic          expire;

    assign mem_op  = rom_load | rom_store;
    // Request is kept outside the FSM process to avoid a loop via the timer
    assign mem_req = (state_q == FETCH) | ((state_q == EXEC) & mem_op);
    assign insr    = insr_q;

    su_bus_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .req_i    (mem_req),
        .ack_i    (mem_ack),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        insr_d     = insr_q;
        mem_ifetch = 1'b0;
        fetch      = 1'b0;
        insr_le    = 1'b0;
        ce_n       = 1'b1;
        wb_stb     = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        bus_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_ifetch = 1'b1;
                if (mem_ack) begin
                    insr_d  = mem_rdata;
                    state_d = INCR;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            INCR: begin
                ce_n    = 1'b0;
                fetch   = 1'b1;
                insr_le = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = (insr_q == HALT_OPC) ? HALT : EXEC;
            end
            EXEC: begin
                ce_n = 1'b0;
                if (!mem_op || mem_ack) begin
                    wb_stb  = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (!run) state_d = IDLE;
            end
            ERR: begin
                busy    = 1'b0;
                bus_err = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            insr_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            insr_q  <= insr_d;
        end
    end

endmodule

// File: tb/tb_su_seq_ctrl.sv
// Directed bench for su_seq_ctrl: per-cycle vector table plus
// hand sequences for timeout, late ack and asynchronous reset.
module tb_su_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic       mem_ifetch;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       rom_load;
    logic       rom_store;
    logic [7:0] insr;
    logic       fetch;
    logic       insr_le;
    logic       ce_n;
    logic       wb_stb;
    logic       busy;
    logic       halted;
    logic       bus_err;

    int nchk = 0;
    int nerr = 0;

    su_seq_ctrl #(
        .MEM_TIMEOUT(16),
        .HALT_OPC   (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_ifetch(mem_ifetch),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rom_load  (rom_load),
        .rom_store (rom_store),
        .insr      (insr),
        .fetch     (fetch),
        .insr_le   (insr_le),
        .ce_n      (ce_n),
        .wb_stb    (wb_stb),
        .busy      (busy),
        .halted    (halted),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] REQ = 9'h100;
    localparam logic [8:0] IFE = 9'h080;
    localparam logic [8:0] FET = 9'h040;
    localparam logic [8:0] ILE = 9'h020;
    localparam logic [8:0] CEN = 9'h010;
    localparam logic [8:0] WB  = 9'h008;
    localparam logic [8:0] BSY = 9'h004;
    localparam logic [8:0] HLT = 9'h002;
    localparam logic [8:0] BER = 9'h001;

    localparam logic [8:0] S_IDLE = CEN;
    localparam logic [8:0] S_FET  = REQ | IFE | CEN | BSY;
    localparam logic [8:0] S_INC  = FET | ILE | BSY;
    localparam logic [8:0] S_DEC  = CEN | BSY;
    localparam logic [8:0] S_NOP  = WB | BSY;
    localparam logic [8:0] S_MW   = REQ | BSY;
    localparam logic [8:0] S_MA   = REQ | WB | BSY;
    localparam logic [8:0] S_HLT  = HLT | CEN;
    localparam logic [8:0] S_ERR  = BER | CEN;

    logic [8:0] obs;
    assign obs = {mem_req, mem_ifetch, fetch, insr_le, ce_n,
                  wb_stb, busy, halted, bus_err};

    typedef struct {
        logic       run;
        logic       ack;
        logic [7:0] rd;
        logic       ld;
        logic       st;
        logic [8:0] eo;
        logic [7:0] ei;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic a, input logic [7:0] d,
                       input logic l, input logic s,
                       input logic [8:0] eo, input logic [7:0] ei);
        vq.push_back('{r, a, d, l, s, eo, ei});
    endtask

    task automatic chk(input string nm, input logic [8:0] eo,
                       input logic [7:0] ei);
        nchk++;
        if (obs !== eo || insr !== ei) begin
            nerr++;
            $display("FAIL %s: got outs=%03h insr=%02h want outs=%03h insr=%02h",
                     nm, obs, insr, eo, ei);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic [7:0] d,
                         input logic l, input logic s);
        run       = r;
        mem_ack   = a;
        mem_rdata = d;
        rom_load  = l;
        rom_store = s;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk(nm, S_IDLE, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // run  ack  rdata  ld  st  expected outs  insr
        add(0, 0, 8'h00, 0, 0, S_IDLE, 8'h00);
        add(1, 1, 8'h01, 0, 0, S_IDLE, 8'h00);
        add(1, 1, 8'h01, 0, 0, S_FET,  8'h00);
        add(1, 1, 8'h55, 0, 0, S_INC,  8'h01);
        add(1, 1, 8'h66, 0, 0, S_DEC,  8'h01);
        add(1, 1, 8'h77, 0, 0, S_NOP,  8'h01);
        add(1, 1, 8'h02, 0, 0, S_FET,  8'h01);
        add(1, 1, 8'h00, 0, 0, S_INC,  8'h02);
        add(1, 1, 8'h00, 0, 0, S_DEC,  8'h02);
        add(1, 1, 8'h00, 0, 0, S_NOP,  8'h02);
        add(1, 1, 8'hB0, 0, 0, S_FET,  8'h02);
        add(1, 1, 8'h00, 0, 0, S_INC,  8'hB0);
        add(1, 0, 8'h00, 0, 0, S_DEC,  8'hB0);
        add(1, 0, 8'h11, 1, 0, S_MW,   8'hB0);
        add(1, 0, 8'h22, 1, 0, S_MW,   8'hB0);
        add(1, 0, 8'h33, 1, 0, S_MW,   8'hB0);
        add(1, 1, 8'h44, 1, 0, S_MA,   8'hB0);
        add(1, 1, 8'hFF, 0, 0, S_FET,  8'hB0);
        add(1, 1, 8'h00, 0, 0, S_INC,  8'hFF);
        add(1, 1, 8'h00, 0, 0, S_DEC,  8'hFF);
        add(1, 1, 8'h00, 0, 0, S_HLT,  8'hFF);
        add(0, 1, 8'h00, 0, 0, S_HLT,  8'hFF);
        add(0, 1, 8'h00, 0, 0, S_IDLE, 8'hFF);
        add(1, 1, 8'h00, 0, 0, S_IDLE, 8'hFF);
        add(1, 1, 8'hB8, 0, 0, S_FET,  8'hFF);
        add(1, 1, 8'h00, 0, 0, S_INC,  8'hB8);
        add(1, 0, 8'h00, 0, 0, S_DEC,  8'hB8);
        add(0, 0, 8'h00, 0, 1, S_MW,   8'hB8);
        add(0, 1, 8'h00, 0, 1, S_MA,   8'hB8);
        add(0, 1, 8'h00, 0, 1, S_IDLE, 8'hB8);
        add(0, 1, 8'h00, 0, 0, S_IDLE, 8'hB8);

        do_reset("reset0");
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].run, vq[i].ack, vq[i].rd, vq[i].ld, vq[i].st);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vq[i].eo, vq[i].ei);
            next();
        end

        // Asynchronous reset while a fetch is stalled
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        next();
        @(negedge clk);
        chk("rst_pre", S_FET, 8'hB8);
        #2 rst = 1'b1;
        #1 chk("rst_async", S_IDLE, 8'h00);
        next();
        rst = 1'b0;

        // Never ack: 16 stalled fetch cycles then ERR
        do_reset("reset1");
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        next();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_err) break;
            if (mem_req) cnt++;
            next();
        end
        nchk++;
        if (cnt != 16) begin
            nerr++;
            $display("FAIL timeout_len: got %0d stalled cycles want 16", cnt);
        end
        chk("err_state", S_ERR, 8'h00);
        drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
        repeat (3) next();
        @(negedge clk);
        chk("err_sticky", S_ERR, 8'h00);

        // Ack on the last allowed cycle wins over the timeout
        do_reset("reset2");
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        next();
        repeat (15) next();
        drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        chk("ack16_fetch", S_FET, 8'h00);
        next();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("ack16_incr", S_INC, 8'h3C);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
